mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Iterative 32-bit multiply/divide unit for MULT/MULTU/DIV/DIVU, with the HI/LO registers.
//  Sits in EX beside the 32-bit Adder; shares its A/B operand buses; feeds HI/LO to write-back.
//  One-bit-per-cycle shift-add multiply, restoring divide; fixed latency; start/busy/done handshake.
// PARAMETERS
//  WIDTH   32   operand width; HI and LO are each WIDTH bits wide
//  CNT_W   6    iteration counter width; must hold WIDTH
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      synchronous active-low reset
//  start        in   1      launch request; sampled only in IDLE
//  op           in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  A            in   32     multiplicand / dividend
//  B            in   32     multiplier / divisor
//  busy         out  1      operation in flight
//  done         out  1      1-cycle pulse; HI/LO valid and updated
//  div_by_zero  out  1      1-cycle pulse with done; divide with B==0
//  hi           out  32     HI register
//  lo           out  32     LO register
// BEHAVIOUR
//  - Reset: one clock, synchronous, active-low, on rst_n.
//    Applies on any edge with rst_n=0, including mid-operation.
//    Reset values: state=IDLE; busy, done, div_by_zero = 0; hi, lo = 0.
//    Any in-flight result is discarded.
//  - States and transitions:
//    IDLE -> RUN on start: latch A, B, op; latch |A| and |B| for signed ops; count=0.
//    RUN: one iteration per cycle; after 32 iterations -> SIGN.
//    SIGN: apply result sign, write hi/lo, assert done -> IDLE.
//  - Timing:
//    start sampled at edge E0; busy=1 after E0 until E33.
//    done=1 for exactly the cycle following E33; hi/lo updated at E33.
//    Fixed latency of 33 cycles for every op, including divide by zero.
//  - start while busy: ignored; no queuing.
//    start in IDLE while done=1 (back-to-back): accepted.
//  - hi/lo hold their value between operations and during RUN.
//    Old values stay visible until E33.
//  - Multiply: 64-bit product {hi,lo}.
//    MULT: signed; negate the 64-bit product iff sign(A) != sign(B).
//    MULTU: unsigned.
//  - Divide: lo = quotient, truncated toward zero; hi = remainder.
//    DIV remainder takes the sign of the dividend. DIVU unsigned.
//    DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; no flag.
//  - Divide with B==0 (DIV or DIVU):
//    lo = 0xFFFFFFFF, hi = A unchanged; div_by_zero pulses with done.
//  - div_by_zero is never asserted for multiply ops.
//  - op, A and B may change after E0 without effect on the running operation.
// CONFIGURATION
//  MDU_HILO_WRITE_EN defined:
//    Adds ports hilo_we (in, 2: bit1=HI, bit0=LO) and hilo_wdata (in, 32) for MTHI/MTLO.
//    A write takes effect at the next edge, only in IDLE.
//    Writes while busy are dropped.
//    start and a write in the same IDLE cycle: start wins; the write is dropped.
//  MDU_HILO_WRITE_EN undefined:
//    Ports absent; hi/lo change only on reset or operation completion.
// TESTING
//  1. MULT A=0xFFFFFFFF B=0x00000002 -> hi=0xFFFFFFFF lo=0xFFFFFFFE; done 33 cycles after start.
//  2. MULTU A=0x80000000 B=0x80000000 -> hi=0x40000000 lo=0x00000000; div_by_zero=0.
//  3. DIV A=0xFFFFFFF9 B=0x00000002 -> lo=0xFFFFFFFD hi=0xFFFFFFFF.
//     DIVU same operands -> lo=0x7FFFFFFC hi=0x00000001.
//  4. DIVU A=0x00000007 B=0 -> lo=0xFFFFFFFF hi=0x00000007; div_by_zero=1 with done.
//     DIV A=0x80000000 B=0xFFFFFFFF -> lo=0x80000000 hi=0.
//  5. Second start (MULTU 3*3) at cycle 5 of a MULTU 2*2 -> ignored; result hi=0 lo=4.
//     Back-to-back start in the done cycle -> second op done 33 cycles later.
//  6. rst_n=0 at cycle 10 of DIV -> next edge: busy=0 done=0 hi=0 lo=0; no done pulse.
//     With MDU_HILO_WRITE_EN: hilo_we=2'b10, data 0x12345678 in IDLE -> hi=0x12345678, lo unchanged.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit (MULT/MULTU/DIV/DIVU) owning the HI/LO registers.
// Optional MTHI/MTLO write port enabled by defining MDU_HILO_WRITE_EN.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef MDU_HILO_WRITE_EN
    input  logic [1:0]       hilo_we,
    input  logic [WIDTH-1:0] hilo_wdata,
`endif
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_SIGN = 2'b10
    } state_t;

    state_t             state_r;
    logic [1:0]         op_r;
    logic [CNT_W-1:0]   count_r;
    logic [WIDTH-1:0]   a_r;
    logic               a_neg_r;
    logic               b_neg_r;
    logic               b_zero_r;
    logic [WIDTH-1:0]   opd_r;
    logic [WIDTH-1:0]   acc_r;
    logic [WIDTH-1:0]   q_r;

    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_shift_s;
    logic [WIDTH:0]     div_diff_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] res_prod_s;
    logic [WIDTH-1:0]   res_quot_s;
    logic [WIDTH-1:0]   res_rem_s;

    function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] x);
        return (~x) + WIDTH'(1);
    endfunction

    function automatic logic [2*WIDTH-1:0] f_neg2(input logic [2*WIDTH-1:0] x);
        return (~x) + (2*WIDTH)'(1);
    endfunction

    function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] x, input logic is_signed);
        if (is_signed && x[WIDTH-1]) begin
            return f_neg(x);
        end else begin
            return x;
        end
    endfunction

    // One iteration of shift-add multiply and restoring divide on the magnitudes.
    always_comb begin
        mul_sum_s   = {1'b0, acc_r} + (q_r[0] ? {1'b0, opd_r} : {(WIDTH+1){1'b0}});
        div_shift_s = {acc_r, q_r[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, opd_r};
    end

    // Final sign correction: product sign is sign(A)^sign(B); remainder follows the dividend.
    always_comb begin
        prod_s = {acc_r, q_r};
        if (op_r == OP_MULT && (a_neg_r ^ b_neg_r)) begin
            res_prod_s = f_neg2(prod_s);
        end else begin
            res_prod_s = prod_s;
        end
        if (op_r == OP_DIV && (a_neg_r ^ b_neg_r)) begin
            res_quot_s = f_neg(q_r);
        end else begin
            res_quot_s = q_r;
        end
        if (op_r == OP_DIV && a_neg_r) begin
            res_rem_s = f_neg(acc_r);
        end else begin
            res_rem_s = acc_r;
        end
    end

    // Control FSM, iteration datapath and HI/LO result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            op_r        <= 2'b00;
            count_r     <= {CNT_W{1'b0}};
            a_r         <= {WIDTH{1'b0}};
            a_neg_r     <= 1'b0;
            b_neg_r     <= 1'b0;
            b_zero_r    <= 1'b0;
            opd_r       <= {WIDTH{1'b0}};
            acc_r       <= {WIDTH{1'b0}};
            q_r         <= {WIDTH{1'b0}};
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= {WIDTH{1'b0}};
            lo          <= {WIDTH{1'b0}};
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r  <= ST_RUN;
                        busy     <= 1'b1;
                        op_r     <= op;
                        count_r  <= {CNT_W{1'b0}};
                        a_r      <= A;
                        a_neg_r  <= ~op[0] & A[WIDTH-1];
                        b_neg_r  <= ~op[0] & B[WIDTH-1];
                        b_zero_r <= (B == {WIDTH{1'b0}});
                        acc_r    <= {WIDTH{1'b0}};
                        // Divide walks the dividend through q_r; multiply walks the multiplier.
                        if (op[1]) begin
                            opd_r <= f_mag(B, ~op[0]);
                            q_r   <= f_mag(A, ~op[0]);
                        end else begin
                            opd_r <= f_mag(A, ~op[0]);
                            q_r   <= f_mag(B, ~op[0]);
                        end
                    end else begin
`ifdef MDU_HILO_WRITE_EN
                        if (hilo_we[1]) begin
                            hi <= hilo_wdata;
                        end
                        if (hilo_we[0]) begin
                            lo <= hilo_wdata;
                        end
`endif
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (op_r[1]) begin
                        if (!div_diff_s[WIDTH]) begin
                            acc_r <= div_diff_s[WIDTH-1:0];
                            q_r   <= {q_r[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_r <= div_shift_s[WIDTH-1:0];
                            q_r   <= {q_r[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc_r <= mul_sum_s[WIDTH:1];
                        q_r   <= {mul_sum_s[0], q_r[WIDTH-1:1]};
                    end
                    count_r <= count_r + CNT_W'(1);
                    if (count_r == CNT_W'(WIDTH-1)) begin
                        state_r <= ST_SIGN;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_SIGN: begin
                    case (op_r)
                        OP_MULT, OP_MULTU: begin
                            hi <= res_prod_s[2*WIDTH-1:WIDTH];
                            lo <= res_prod_s[WIDTH-1:0];
                        end
                        OP_DIV, OP_DIVU: begin
                            if (b_zero_r) begin
                                hi          <= a_r;
                                lo          <= {WIDTH{1'b1}};
                                div_by_zero <= 1'b1;
                            end else begin
                                hi <= res_rem_s;
                                lo <= res_quot_s;
                            end
                        end
                        default: begin
                            hi <= hi;
                            lo <= lo;
                        end
                    endcase
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed table, randomized ops against an
// arithmetic reference model, and hand sequences for busy/back-to-back/reset corners.
module tb_mult_div_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;
`ifdef MDU_HILO_WRITE_EN
    logic [1:0]  hilo_we;
    logic [31:0] hilo_wdata;
`endif

    int total;
    int passed;

    mult_div_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .A           (A),
        .B           (B),
`ifdef MDU_HILO_WRITE_EN
        .hilo_we     (hilo_we),
        .hilo_wdata  (hilo_wdata),
`endif
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic from the instruction definitions.
    task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] e_hi, output logic [31:0] e_lo, output logic e_dbz);
        int     sa;
        int     sb;
        longint la;
        longint lb;
        longint r;
        logic [63:0] u;
        sa = a;
        sb = b;
        la = sa;
        lb = sb;
        e_dbz = 1'b0;
        case (o)
            2'b00: begin
                r = la * lb;
                u = r;
                e_hi = u[63:32];
                e_lo = u[31:0];
            end
            2'b01: begin
                u = {32'd0, a} * {32'd0, b};
                e_hi = u[63:32];
                e_lo = u[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    e_hi = a;
                    e_lo = 32'hFFFFFFFF;
                    e_dbz = 1'b1;
                end else if (o == 2'b10) begin
                    r = la / lb;
                    u = r;
                    e_lo = u[31:0];
                    r = la % lb;
                    u = r;
                    e_hi = u[31:0];
                end else begin
                    e_lo = a / b;
                    e_hi = a % b;
                end
            end
        endcase
    endtask

    // Launch one op, optionally re-assert start mid-flight, and check latency and results.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int inject, input logic [31:0] e_hi, input logic [31:0] e_lo,
                          input logic e_dbz, input string nm);
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        logic        ok;
        int          k;
        @(negedge clk);
        old_hi = hi;
        old_lo = lo;
        start = 1'b1;
        op = o;
        A = a;
        B = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        op = 2'($urandom);
        A = $urandom;
        B = $urandom;
        chk({nm, "_busy"}, {63'd0, busy}, 64'd1);
        ok = 1'b1;
        k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            if (k == inject) begin
                start = 1'b1;
                op = 2'b01;
                A = 32'd3;
                B = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            k++;
            if (!done && (!busy || hi !== old_hi || lo !== old_lo || div_by_zero)) ok = 1'b0;
        end
        start = 1'b0;
        chk({nm, "_latency"}, 64'(k), 64'd33);
        chk({nm, "_inflight"}, {63'd0, ok}, 64'd1);
        chk({nm, "_result"}, {hi, lo}, {e_hi, e_lo});
        chk({nm, "_dbz_busy"}, {62'd0, div_by_zero, busy}, {62'd0, e_dbz, 1'b0});
    endtask

    initial begin
        vec_t        vecs[7];
        logic [31:0] e_hi;
        logic [31:0] e_lo;
        logic        e_dbz;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        int          k;
        logic        seen;

        vecs[0] = '{2'b00, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
        vecs[1] = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[2] = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3] = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC, 1'b0};
        vecs[4] = '{2'b11, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1'b1};
        vecs[5] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[6] = '{2'b10, 32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1};

        total = 0;
        passed = 0;
        rst_n = 1'b0;
        start = 1'b0;
        op = 2'b00;
        A = 32'd0;
        B = 32'd0;
`ifdef MDU_HILO_WRITE_EN
        hilo_we = 2'b00;
        hilo_wdata = 32'd0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {29'd0, busy, done, div_by_zero, hi, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, -1, vecs[i].hi, vecs[i].lo, vecs[i].dbz,
                   $sformatf("vec%0d", i));
        end

        @(posedge clk);
        #1;
        chk("done_one_cycle", {62'd0, done, div_by_zero}, 64'd0);

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0: ra = 32'd0;
                1: ra = 32'h80000000;
                2: ra = 32'hFFFFFFFF;
                3: ra = 32'($urandom_range(0, 20));
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'h80000000;
                2: rb = 32'hFFFFFFFF;
                3: rb = 32'($urandom_range(0, 20));
                default: rb = $urandom;
            endcase
            model(ro, ra, rb, e_hi, e_lo, e_dbz);
            run_op(ro, ra, rb, -1, e_hi, e_lo, e_dbz, $sformatf("rnd%0d", i));
        end

        // A start raised while busy must be ignored.
        run_op(2'b01, 32'd2, 32'd2, 4, 32'd0, 32'd4, 1'b0, "start_while_busy");
        chk("b2b_done_high", {63'd0, done}, 64'd1);
        run_op(2'b01, 32'd5, 32'd6, -1, 32'd0, 32'd30, 1'b0, "back_to_back");

        // Reset in the middle of a divide discards it.
        @(negedge clk);
        start = 1'b1;
        op = 2'b10;
        A = 32'd100;
        B = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midop_reset", {29'd0, busy, done, div_by_zero, hi, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen = 1'b1;
        end
        chk("no_done_after_reset", {63'd0, seen}, 64'd0);

`ifdef MDU_HILO_WRITE_EN
        run_op(2'b01, 32'd3, 32'd5, -1, 32'd0, 32'd15, 1'b0, "pre_write");
        @(negedge clk);
        hilo_we = 2'b10;
        hilo_wdata = 32'h12345678;
        @(posedge clk);
        #1;
        hilo_we = 2'b00;
        chk("mthi", {hi, lo}, {32'h12345678, 32'd15});
        @(negedge clk);
        start = 1'b1;
        op = 2'b01;
        A = 32'd2;
        B = 32'd3;
        hilo_we = 2'b11;
        hilo_wdata = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("start_wins", {hi, lo}, {32'h12345678, 32'd15});
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("write_busy_dropped", {hi, lo}, {32'h12345678, 32'd15});
        hilo_we = 2'b00;
        k = 0;
        while (!done && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("after_write_result", {hi, lo}, {32'd0, 32'd6});
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
